// File: rtl/fp_addsub_pipe.sv
// rtl/fp_addsub_pipe.sv - pipelined IEEE-754 add/sub with RNE rounding, specials and status flags
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         flag_nv,
    output logic         flag_of,
    output logic         flag_nx
);
    localparam int MW = MAN_W + 5;
    localparam int EW = EXP_W + 1;
    localparam logic [EW-1:0] SH_CAP = EW'(MAN_W + 3);
    localparam logic [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Operand capture rank
    logic v0_q, v0_d, sub0_q, sub0_d;
    logic [W-1:0] a0_q, a0_d, b0_q, b0_d;
    // S1: unpack / classify / align
    logic v1_q, v1_d, spec1_q, spec1_d, snv1_q, snv1_d, sign1_q, sign1_d;
    logic zsign1_q, zsign1_d, esub1_q, esub1_d;
    logic [W-1:0]  sres1_q, sres1_d;
    logic [EW-1:0] exp1_q, exp1_d;
    logic [MW-1:0] mb1_q, mb1_d, ms1_q, ms1_d;
    // S2: signed mantissa add
    logic v2_q, v2_d, spec2_q, spec2_d, snv2_q, snv2_d, sign2_q, sign2_d;
    logic [W-1:0]  sres2_q, sres2_d;
    logic [EW-1:0] exp2_q, exp2_d;
    logic [MW-1:0] sum2_q, sum2_d;
    // S3: normalise / round / pack
    logic v3_q, v3_d, nv3_q, nv3_d, of3_q, of3_d, nx3_q, nx3_d;
    logic [W-1:0] res3_q, res3_d;

    logic               sa, sb, a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, a_big;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic [EW-1:0]      eea, eeb, e_big, e_sml, e_diff, sh;
    logic [MW-1:0]      ma, mb, m_big, m_sml;
    logic [2*MW-1:0]    wide;

    always_comb begin
        v0_d   = in_valid;
        a0_d   = a;
        b0_d   = b;
        sub0_d = sub;

        sa     = a0_q[W-1];
        sb     = b0_q[W-1] ^ sub0_q;
        ea     = a0_q[W-2:MAN_W];
        eb     = b0_q[W-2:MAN_W];
        fa     = a0_q[MAN_W-1:0];
        fb     = b0_q[MAN_W-1:0];
        a_nan  = (&ea) & (|fa);
        b_nan  = (&eb) & (|fb);
        a_inf  = (&ea) & ~(|fa);
        b_inf  = (&eb) & ~(|fb);
        a_snan = a_nan & ~fa[MAN_W-1];
        b_snan = b_nan & ~fb[MAN_W-1];
        // Subnormals share the minimum normal exponent, with no hidden bit
        eea    = (ea == '0) ? EW'(1) : {1'b0, ea};
        eeb    = (eb == '0) ? EW'(1) : {1'b0, eb};
        ma     = {1'b0, |ea, fa, 3'b000};
        mb     = {1'b0, |eb, fb, 3'b000};
        a_big  = {eea, ma} >= {eeb, mb};
        e_big  = a_big ? eea : eeb;
        e_sml  = a_big ? eeb : eea;
        m_big  = a_big ? ma : mb;
        m_sml  = a_big ? mb : ma;
        e_diff = e_big - e_sml;
        sh     = (e_diff > SH_CAP) ? SH_CAP : e_diff;
        wide   = {m_sml, {MW{1'b0}}} >> sh;

        v1_d     = v0_q;
        exp1_d   = e_big;
        mb1_d    = m_big;
        ms1_d    = {wide[2*MW-1:MW+1], wide[MW] | (|wide[MW-1:0])};
        sign1_d  = a_big ? sa : sb;
        zsign1_d = sa & sb;
        esub1_d  = sa ^ sb;
        spec1_d  = a_nan | b_nan | a_inf | b_inf;
        sres1_d  = QNAN;
        snv1_d   = 1'b0;
        if (a_nan | b_nan) begin
            snv1_d = a_snan | b_snan;
        end else if (a_inf & b_inf & (sa != sb)) begin
            snv1_d = 1'b1;
        end else if (a_inf) begin
            sres1_d = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            sres1_d = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    always_comb begin
        v2_d    = v1_q;
        spec2_d = spec1_q;
        sres2_d = sres1_q;
        snv2_d  = snv1_q;
        exp2_d  = exp1_q;
        sum2_d  = esub1_q ? (mb1_q - ms1_q) : (mb1_q + ms1_q);
        sign2_d = (sum2_d == '0) ? zsign1_q : sign1_q;
    end

    logic [EW-1:0]    lz, lim, nsh, e;
    logic [MW-2:0]    m;
    logic [MAN_W+1:0] mr;
    logic             inc;

    always_comb begin
        lz = EW'(MW - 1);
        for (int i = 0; i < MW - 1; i++) begin
            if (sum2_q[i]) lz = EW'(MW - 2 - i);
        end
        lim = exp2_q - EW'(1);
        nsh = (lz > lim) ? lim : lz;
        if (sum2_q[MW-1]) begin
            m    = sum2_q[MW-1:1];
            m[0] = sum2_q[1] | sum2_q[0];
            e    = exp2_q + EW'(1);
        end else begin
            m = sum2_q[MW-2:0] << nsh;
            e = exp2_q - nsh;
        end
        inc = m[2] & (m[1] | m[0] | m[3]);
        mr  = {1'b0, m[MW-2:3]} + (MAN_W+2)'(inc);
        if (mr[MAN_W+1]) begin
            mr = mr >> 1;
            e  = e + EW'(1);
        end

        v3_d  = v2_q;
        nv3_d = 1'b0;
        of3_d = 1'b0;
        nx3_d = m[2] | m[1] | m[0];
        // Hidden bit clear after normalise/round means the result stays subnormal
        res3_d = {sign2_q, mr[MAN_W] ? e[EXP_W-1:0] : {EXP_W{1'b0}}, mr[MAN_W-1:0]};
        if (e >= E_MAX) begin
            res3_d = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            of3_d  = 1'b1;
            nx3_d  = 1'b1;
        end
        if (spec2_q) begin
            res3_d = sres2_q;
            nv3_d  = snv2_q;
            of3_d  = 1'b0;
            nx3_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q <= 1'b0; a0_q <= '0; b0_q <= '0; sub0_q <= 1'b0;
            v1_q <= 1'b0; spec1_q <= 1'b0; sres1_q <= '0; snv1_q <= 1'b0; sign1_q <= 1'b0;
            zsign1_q <= 1'b0; esub1_q <= 1'b0; exp1_q <= '0; mb1_q <= '0; ms1_q <= '0;
            v2_q <= 1'b0; spec2_q <= 1'b0; sres2_q <= '0; snv2_q <= 1'b0; sign2_q <= 1'b0;
            exp2_q <= '0; sum2_q <= '0;
            v3_q <= 1'b0; res3_q <= '0; nv3_q <= 1'b0; of3_q <= 1'b0; nx3_q <= 1'b0;
        end else if (adv) begin
            v0_q <= v0_d; a0_q <= a0_d; b0_q <= b0_d; sub0_q <= sub0_d;
            v1_q <= v1_d; spec1_q <= spec1_d; sres1_q <= sres1_d; snv1_q <= snv1_d; sign1_q <= sign1_d;
            zsign1_q <= zsign1_d; esub1_q <= esub1_d; exp1_q <= exp1_d; mb1_q <= mb1_d; ms1_q <= ms1_d;
            v2_q <= v2_d; spec2_q <= spec2_d; sres2_q <= sres2_d; snv2_q <= snv2_d; sign2_q <= sign2_d;
            exp2_q <= exp2_d; sum2_q <= sum2_d;
            v3_q <= v3_d; res3_q <= res3_d; nv3_q <= nv3_d; of3_q <= of3_d; nx3_q <= nx3_d;
        end
    end

    assign out_valid = v3_q;
    assign result    = res3_q;
    assign flag_nv   = nv3_q;
    assign flag_of   = of3_q;
    assign flag_nx   = nx3_q;
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb/tb_fp_addsub_pipe.sv - scoreboard bench for fp_addsub_pipe (binary32)
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0, b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        flag_nv, flag_of, flag_nx;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_nv(flag_nv), .flag_of(flag_of), .flag_nx(flag_nx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [34:0] e;   // {result, nv, of, nx}
    } vec_t;

    vec_t        vt[18];
    logic [34:0] exp_q[$];
    logic [34:0] obs_q[$];
    int          checks = 0;
    int          failures = 0;
    bit          ready_mode = 1'b0;
    int          rcnt = 0;

    // out_ready pattern 1,0,0 repeating when ready_mode is set
    initial forever begin
        @(posedge clk);
        #2;
        if (ready_mode) begin
            out_ready = (rcnt % 3 == 0);
            rcnt++;
        end else begin
            out_ready = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready)
            obs_q.push_back({result, flag_nv, flag_of, flag_nx});
    end

    task automatic send(input int idx);
        int n;
        a = vt[idx].a;
        b = vt[idx].b;
        sub = vt[idx].s;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL send_accept idx=%0d in_ready=%b required=1", idx, in_ready);
        end else begin
            exp_q.push_back(vt[idx].e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (obs_q.size() < exp_q.size() && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h required=00000000", result); end
        checks++; if ({flag_nv, flag_of, flag_nx} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b required=000", {flag_nv, flag_of, flag_nx}); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        @(posedge clk);
        #1;
        a = vt[0].a; b = vt[0].b; sub = vt[0].s; in_valid = 1'b1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lat_in_ready got=%b required=1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== (k == 3)) begin
                failures++;
                $display("FAIL lat_out_valid edge=N+%0d got=%b required=%b", k, out_valid, (k == 3));
            end
        end
        checks++;
        if ({result, flag_nv, flag_of, flag_nx} !== vt[0].e) begin
            failures++;
            $display("FAIL lat_result got=%h required=%h", {result, flag_nv, flag_of, flag_nx}, vt[0].e);
        end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_bubble got=%b required=0", out_valid); end
        obs_q.delete();
    endtask

    task automatic test_arith();
        logic [34:0] e, o;
        int k = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) send(i);
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL arith_%0d got=none required=%h", k, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL arith_%0d got=%h required=%h", k, o, e); end
            end
            k++;
        end
    endtask

    task automatic test_specials();
        logic [34:0] e, o;
        int k = 12;
        @(posedge clk);
        #1;
        for (int i = 12; i < 18; i++) send(i);
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL special_%0d got=none required=%h", k, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL special_%0d got=%h required=%h", k, o, e); end
            end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        logic [34:0] e, o, held;
        logic was_stall;
        int stalls, k;
        ready_mode = 1'b1;
        rcnt = 0;
        stalls = 0;
        was_stall = 1'b0;
        held = '0;
        k = 0;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 18; i++) send(i);
            end
            begin
                for (int c = 0; c < 120; c++) begin
                    @(negedge clk);
                    if (was_stall) begin
                        checks++;
                        if (!out_valid || {result, flag_nv, flag_of, flag_nx} !== held) begin
                            failures++;
                            $display("FAIL stall_hold valid=%b got=%h required=%h", out_valid,
                                     {result, flag_nv, flag_of, flag_nx}, held);
                        end
                    end
                    was_stall = out_valid && !out_ready;
                    held = {result, flag_nv, flag_of, flag_nx};
                    if (was_stall) stalls++;
                end
            end
        join
        checks++; if (stalls == 0) begin failures++; $display("FAIL stall_seen got=0 required=nonzero"); end
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL b2b_%0d got=none required=%h", k, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL b2b_%0d got=%h required=%h", k, o, e); end
            end
            k++;
        end
        repeat (10) @(negedge clk);
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL b2b_extra got=%0d required=0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_reset_midstream();
        logic [34:0] e, o;
        int n = 0;
        int k = 0;
        ready_mode = 1'b1;
        rcnt = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(i);
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b required=1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b required=0", out_valid); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL mid_async_result got=%h required=00000000", result); end
        exp_q.delete();
        obs_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 1'b0;
        for (int i = 12; i < 15; i++) send(i);
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL mid_fresh_%0d got=none required=%h", k, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL mid_fresh_%0d got=%h required=%h", k, o, e); end
            end
            k++;
        end
        repeat (8) @(negedge clk);
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL mid_stale got=%0d required=0", obs_q.size()); end
    endtask

    initial begin
        vt[0]  = '{32'h3F800000, 32'h40000000, 1'b0, {32'h40400000, 3'b000}};
        vt[1]  = '{32'h3F800000, 32'h33800000, 1'b0, {32'h3F800000, 3'b001}};
        vt[2]  = '{32'h3F800001, 32'h33800000, 1'b0, {32'h3F800002, 3'b001}};
        vt[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {32'h7F800000, 3'b011}};
        vt[4]  = '{32'h40000000, 32'h40000000, 1'b1, {32'h00000000, 3'b000}};
        vt[5]  = '{32'h00000001, 32'h00000001, 1'b0, {32'h00000002, 3'b000}};
        vt[6]  = '{32'h00800000, 32'h00000001, 1'b1, {32'h007FFFFF, 3'b000}};
        vt[7]  = '{32'h3F800000, 32'h40400000, 1'b1, {32'hC0000000, 3'b000}};
        vt[8]  = '{32'h3F800000, 32'h33C00000, 1'b0, {32'h3F800001, 3'b001}};
        vt[9]  = '{32'h3FC00000, 32'h3FA00000, 1'b1, {32'h3E800000, 3'b000}};
        vt[10] = '{32'h80000000, 32'h80000000, 1'b0, {32'h80000000, 3'b000}};
        vt[11] = '{32'h80000000, 32'h00000000, 1'b1, {32'h80000000, 3'b000}};
        vt[12] = '{32'h7F800000, 32'h7F800000, 1'b1, {32'h7FC00000, 3'b100}};
        vt[13] = '{32'h7F800001, 32'h3F800000, 1'b0, {32'h7FC00000, 3'b100}};
        vt[14] = '{32'h7F800000, 32'h3F800000, 1'b0, {32'h7F800000, 3'b000}};
        vt[15] = '{32'h7FC00000, 32'h3F800000, 1'b0, {32'h7FC00000, 3'b000}};
        vt[16] = '{32'hFF800000, 32'h7F800000, 1'b0, {32'h7FC00000, 3'b100}};
        vt[17] = '{32'h3F800000, 32'hFF800000, 1'b1, {32'h7F800000, 3'b000}};

        test_reset();
        test_latency();
        test_arith();
        test_specials();
        test_back_to_back();
        test_reset_midstream();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
